// File: rtl/cpu_step_controller.sv
// cpu_step_controller: paces the single-cycle CPU by issuing a one-cycle
// execute strobe (cpu_en). Supports free-run at a programmable tick rate,
// debounced single-step from a push button, and halt-on-breakpoint against
// the CPU's current ReadAddress. Also counts retired instructions.
//
// Strobe semantics: cpu_en is a registered, self-timed strobe with no
// back-pressure. Each cycle it is high the CPU executes exactly one
// instruction, and instr_count advances by one at the end of that cycle.
module cpu_step_controller #(
   parameter int DIV_WIDTH       = 26,
   parameter int DIV_DEFAULT     = 25000000,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ADDR_WIDTH      = 8
) (
   input  logic                  clk50,
   input  logic                  reset,
   input  logic                  run_sw,
   input  logic                  step_btn,
   input  logic                  bp_en,
   input  logic [ADDR_WIDTH-1:0] bp_addr,
   input  logic                  div_load,
   input  logic [DIV_WIDTH-1:0]  div_value,
   input  logic [ADDR_WIDTH-1:0] ReadAddress,
   output logic                  cpu_en,
   output logic                  cpu_halted,
   output logic [1:0]            state,
   output logic [15:0]           instr_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_STEP  = 2'b10,
      S_BREAK = 2'b11
   } state_t;

   localparam int                   DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   // A zero divider is meaningless, so it is stored as 1 (strobe every cycle).
   localparam logic [DIV_WIDTH-1:0] DIV_RST = (DIV_DEFAULT == 0) ? DIV_WIDTH'(1)
                                                                 : DIV_WIDTH'(DIV_DEFAULT);

   state_t                 state_q, state_d;
   logic                   cpu_en_d;
   logic                   sync1_q, sync2_q;
   logic                   db_level_q, db_prev_q;
   logic [DB_W-1:0]        db_cnt_q;
   logic                   step_pulse_q;
   logic [DIV_WIDTH-1:0]   div_reg_q;
   logic [DIV_WIDTH-1:0]   div_cnt_q;
   logic                   tick;
   logic                   bp_hit;

   assign state      = state_q;
   assign cpu_halted = (state_q == S_BREAK);

   // Tick fires on the last count of the period; a load cycle restarts the period.
   assign tick   = (state_q == S_RUN) && !div_load &&
                   (div_cnt_q == (div_reg_q - DIV_WIDTH'(1)));
   assign bp_hit = bp_en && (ReadAddress == bp_addr);

   // Two-flop synchroniser for the raw push button.
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= step_btn;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: the synced level must differ for DEBOUNCE_CYCLES straight cycles.
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         db_level_q <= 1'b0;
         db_cnt_q   <= '0;
      end else if (sync2_q == db_level_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_level_q <= sync2_q;
         db_cnt_q   <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + DB_W'(1);
      end
   end

   // Registered one-cycle pulse on each rising edge of the debounced level.
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         db_prev_q    <= 1'b0;
         step_pulse_q <= 1'b0;
      end else begin
         db_prev_q    <= db_level_q;
         step_pulse_q <= db_level_q & ~db_prev_q;
      end
   end

   // Divider register and tick counter; the counter only runs in RUN.
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         div_reg_q <= DIV_RST;
         div_cnt_q <= '0;
      end else if (div_load) begin
         div_reg_q <= (div_value == '0) ? DIV_WIDTH'(1) : div_value;
         div_cnt_q <= '0;
      end else if ((state_q != S_RUN) || tick) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
      end
   end

   // State register; cpu_en is registered from the same decision as the next state.
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cpu_en  <= 1'b0;
      end else begin
         state_q <= state_d;
         cpu_en  <= cpu_en_d;
      end
   end

   // Next-state and strobe decision.
   always_comb begin
      state_d  = state_q;
      cpu_en_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // run_sw wins over a coincident step press, which is dropped.
            if (run_sw) begin
               state_d = S_RUN;
            end else if (step_pulse_q) begin
               state_d  = S_STEP;
               cpu_en_d = 1'b1;
            end
         end
         S_RUN: begin
            if (!run_sw) begin
               state_d = S_IDLE;
            end else if (tick) begin
               // Halting before the strobe leaves the breakpoint instruction unexecuted.
               if (bp_hit) begin
                  state_d = S_BREAK;
               end else begin
                  cpu_en_d = 1'b1;
               end
            end
         end
         S_STEP: begin
            state_d = S_IDLE;
         end
         S_BREAK: begin
            if (step_pulse_q) begin
               state_d  = S_STEP;
               cpu_en_d = 1'b1;
            end else if (!run_sw) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Retired-instruction counter; wraps naturally at 16 bits.
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         instr_count <= 16'h0000;
      end else if (cpu_en) begin
         instr_count <= instr_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed scenarios push expected strobes
// (cycle, state, instr_count) into a queue; a negedge monitor pops and
// compares each cpu_en strobe against it.
module tb_cpu_step_controller;

   localparam int DIV_WIDTH  = 26;
   localparam int ADDR_WIDTH = 8;
   localparam int EXP_W      = 50;   // {cycle[31:0], state[1:0], count[15:0]}

   logic                  clk50;
   logic                  reset;
   logic                  run_sw;
   logic                  step_btn;
   logic                  bp_en;
   logic [ADDR_WIDTH-1:0] bp_addr;
   logic                  div_load;
   logic [DIV_WIDTH-1:0]  div_value;
   logic [ADDR_WIDTH-1:0] ReadAddress;
   logic                  cpu_en;
   logic                  cpu_halted;
   logic [1:0]            state;
   logic [15:0]           instr_count;

   logic [EXP_W-1:0] exp_q[$];
   logic [15:0]      exp_cnt;
   logic [31:0]      cyc;
   int               n_checks;
   int               n_fail;

   cpu_step_controller #(
      .DIV_WIDTH      (DIV_WIDTH),
      .DIV_DEFAULT    (6),
      .DEBOUNCE_CYCLES(4),
      .ADDR_WIDTH     (ADDR_WIDTH)
   ) dut (
      .clk50      (clk50),
      .reset      (reset),
      .run_sw     (run_sw),
      .step_btn   (step_btn),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .div_load   (div_load),
      .div_value  (div_value),
      .ReadAddress(ReadAddress),
      .cpu_en     (cpu_en),
      .cpu_halted (cpu_halted),
      .state      (state),
      .instr_count(instr_count)
   );

   // ---------------- clock / reset ----------------
   initial clk50 = 1'b0;
   always #5 clk50 = ~clk50;

   initial cyc = 0;
   always @(posedge clk50) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Wait until just after the posedge that brings cyc to c.
   task automatic tick_to(input logic [31:0] c);
      while (cyc < c) begin
         @(posedge clk50);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] c, input logic [1:0] st);
      exp_q.push_back({c, st, exp_cnt});
      exp_cnt = exp_cnt + 16'd1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk50) begin
      logic [EXP_W-1:0] e;
      while (exp_q.size() != 0 && exp_q[0][49:18] < cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL strobe_missing: no cpu_en at cycle %0d, expected one", e[49:18]);
      end
      if (cpu_en === 1'b1) begin
         if (exp_q.size() == 0 || exp_q[0][49:18] != cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_unexpected: cpu_en=1 at cycle %0d, expected 0", cyc);
         end else begin
            e = exp_q.pop_front();
            check("strobe_state", {30'd0, state}, {30'd0, e[17:16]});
            check("strobe_count", {16'd0, instr_count}, {16'd0, e[15:0]});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] n;
      n_checks    = 0;
      n_fail      = 0;
      exp_cnt     = 16'd0;
      reset       = 1'b0;
      run_sw      = 1'b0;
      step_btn    = 1'b0;
      bp_en       = 1'b0;
      bp_addr     = '0;
      div_load    = 1'b0;
      div_value   = '0;
      ReadAddress = '0;

      // Reset values
      #50;
      check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_count", {16'd0, instr_count}, 32'd0);
      check("rst_halted", {31'd0, cpu_halted}, 32'd0);
      #50;
      reset = 1'b1;
      @(posedge clk50);
      #1;

      // Free-run with divider 4
      b = cyc;
      div_load  = 1'b1;
      div_value = 26'd4;
      run_sw    = 1'b1;
      for (int i = 0; i < 5; i++) push_exp(b + 5 + 4 * i, 2'b01);
      tick_to(b + 1);
      div_load = 1'b0;
      check("run_state", {30'd0, state}, 32'd1);
      tick_to(b + 22);
      check("run_count5", {16'd0, instr_count}, 32'd5);
      run_sw = 1'b0;
      tick_to(b + 23);
      check("run_stop_state", {30'd0, state}, 32'd0);
      tick_to(b + 30);

      // Bouncy step press: 1,0,1 then held
      b = cyc;
      step_btn = 1'b1;
      tick_to(b + 1);
      step_btn = 1'b0;
      tick_to(b + 2);
      step_btn = 1'b1;
      push_exp(b + 10, 2'b10);
      tick_to(b + 11);
      check("step_count", {16'd0, instr_count}, 32'd6);
      check("step_back_idle", {30'd0, state}, 32'd0);
      step_btn = 1'b0;
      tick_to(b + 24);

      // Breakpoint at 0x03, divider 1
      b = cyc;
      bp_en       = 1'b1;
      bp_addr     = 8'h03;
      div_load    = 1'b1;
      div_value   = 26'd1;
      run_sw      = 1'b1;
      ReadAddress = 8'h00;
      push_exp(b + 2, 2'b01);
      push_exp(b + 3, 2'b01);
      push_exp(b + 4, 2'b01);
      tick_to(b + 1);
      div_load = 1'b0;
      tick_to(b + 2);
      ReadAddress = 8'h01;
      tick_to(b + 3);
      ReadAddress = 8'h02;
      tick_to(b + 4);
      ReadAddress = 8'h03;
      tick_to(b + 5);
      check("bp_state", {30'd0, state}, 32'd3);
      check("bp_halted", {31'd0, cpu_halted}, 32'd1);
      check("bp_no_strobe", {31'd0, cpu_en}, 32'd0);
      check("bp_count", {16'd0, instr_count}, 32'd9);
      tick_to(b + 8);
      check("bp_held", {30'd0, state}, 32'd3);
      q = cyc;
      step_btn = 1'b1;
      push_exp(q + 8, 2'b10);
      tick_to(q + 8);
      run_sw = 1'b0;
      tick_to(q + 9);
      check("bp_step_idle", {30'd0, state}, 32'd0);
      check("bp_step_count", {16'd0, instr_count}, 32'd10);
      check("bp_step_unhalt", {31'd0, cpu_halted}, 32'd0);
      step_btn = 1'b0;
      bp_en    = 1'b0;
      tick_to(q + 22);

      // run_sw rising together with step_pulse; step ignored in RUN
      b = cyc;
      div_load  = 1'b1;
      div_value = 26'd1000;
      tick_to(b + 1);
      div_load = 1'b0;
      tick_to(b + 2);
      step_btn = 1'b1;
      tick_to(b + 9);
      run_sw = 1'b1;
      tick_to(b + 10);
      check("simul_state", {30'd0, state}, 32'd1);
      check("simul_no_strobe", {31'd0, cpu_en}, 32'd0);
      tick_to(b + 11);
      check("simul_still_run", {30'd0, state}, 32'd1);
      step_btn = 1'b0;
      tick_to(b + 22);
      step_btn = 1'b1;
      tick_to(b + 34);
      check("run_step_ignored", {16'd0, instr_count}, 32'd10);
      check("run_step_state", {30'd0, state}, 32'd1);
      step_btn = 1'b0;

      // div_value=0 loaded in RUN: strobe every cycle, run counter to wrap
      b = cyc;
      div_load  = 1'b1;
      div_value = '0;
      tick_to(b + 1);
      div_load = 1'b0;
      n = 32'd65536 - {16'd0, exp_cnt};
      for (int i = 0; i < int'(n); i++) begin
         tick_to(b + 2 + i);
         push_exp(cyc, 2'b01);
         if (i == int'(n) - 1) begin
            check("pre_wrap_count", {16'd0, instr_count}, 32'd65535);
            run_sw = 1'b0;
         end
      end
      tick_to(b + 2 + n);
      check("wrap_count", {16'd0, instr_count}, 32'd0);
      check("wrap_idle", {30'd0, state}, 32'd0);
      tick_to(b + 6 + n);

      // Asynchronous reset mid-strobe, then default divider (6) in effect
      b = cyc;
      div_load  = 1'b1;
      div_value = 26'd2;
      run_sw    = 1'b1;
      push_exp(b + 3, 2'b01);
      tick_to(b + 1);
      div_load = 1'b0;
      tick_to(b + 3);
      check("pre_reset_strobe", {31'd0, cpu_en}, 32'd1);
      #6;
      reset  = 1'b0;
      run_sw = 1'b0;
      #1;
      exp_cnt = 16'd0;
      check("areset_cpu_en", {31'd0, cpu_en}, 32'd0);
      check("areset_state", {30'd0, state}, 32'd0);
      check("areset_count", {16'd0, instr_count}, 32'd0);
      @(posedge clk50);
      #1;
      reset = 1'b1;
      b = cyc + 1;
      tick_to(b);
      run_sw = 1'b1;
      push_exp(b + 7, 2'b01);
      tick_to(b + 7);
      run_sw = 1'b0;
      tick_to(b + 8);
      check("default_div_count", {16'd0, instr_count}, 32'd1);
      check("default_div_idle", {30'd0, state}, 32'd0);
      tick_to(b + 12);

      check("exp_queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Sequences the 8-bit single-cycle CPU (Main) from clk50 by generating a one-cycle execute strobe, cpu_en, that gates the CPU's PC/register update.
- Modes: free-run at a programmable tick rate, debounced single-step from a push button, and halt-on-breakpoint matched against the CPU's ReadAddress.
- Sits between board switches/buttons and the CPU core; also counts retired instructions for the 7-segment debug display.

Parameters:
- DIV_WIDTH, 26, width of tick divider and div_value.
- DIV_DEFAULT, 25000000, reset divider value (2 Hz at 50 MHz).
- DEBOUNCE_CYCLES, 500000, clk50 cycles step_btn must be stable before the debounced level updates.
- ADDR_WIDTH, 8, width of ReadAddress and bp_addr.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- run_sw  in  1  level; 1 requests free-run.
- step_btn  in  1  raw asynchronous push button, active-high.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_WIDTH  breakpoint instruction address.
- div_load  in  1  loads div_value into the divider register.
- div_value  in  DIV_WIDTH  ticks-per-instruction in RUN.
- ReadAddress  in  ADDR_WIDTH  current PC from the CPU.
- cpu_en  out  1  registered one-cycle execute strobe.
- cpu_halted  out  1  high while in BREAK.
- state  out  2  FSM state: IDLE=00, RUN=01, STEP=10, BREAK=11.
- instr_count  out  16  number of cpu_en strobes issued.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, cpu_en=0, cpu_halted=0, instr_count=0.
  - Divider counter=0, divider register=DIV_DEFAULT.
  - Synchroniser flops=0, debounced level=0, debounce counter=0.
- step_btn path:
  - 2-FF synchroniser, then debounce counter. If the synced level differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level updates; any bounce restarts the count.
  - step_pulse is one cycle on each rising edge of the debounced level.
- Divider:
  - div_load=1 captures div_value and clears the counter in the same cycle.
  - div_value=0 is treated as 1.
  - In RUN, the counter increments each cycle. When it equals divider-1, tick=1 and the counter returns to 0.
  - Outside RUN the counter is held at 0.
- FSM (next-state registered; cpu_en registered from the same decision):
  - IDLE:
    - run_sw=1 -> RUN.
    - Otherwise step_pulse -> STEP, and cpu_en=1 in the next cycle.
    - run_sw=1 takes priority; a step_pulse in the same cycle is dropped.
  - RUN:
    - run_sw=0 -> IDLE; no strobe that cycle even if tick.
    - On tick with bp_en=1 and ReadAddress==bp_addr -> BREAK; strobe suppressed, so the breakpoint instruction is not executed.
    - On any other tick -> cpu_en=1 next cycle; stay in RUN.
    - step_pulse is ignored.
  - STEP:
    - Lasts exactly one cycle; cpu_en=1 during it.
    - Returns to IDLE unconditionally; the breakpoint is not checked.
  - BREAK:
    - cpu_halted=1, cpu_en=0.
    - step_pulse -> STEP, executing the breakpoint instruction once.
    - Otherwise run_sw=0 -> IDLE.
    - BREAK is only left via a step or run_sw=0; resuming RUN requires IDLE.
- cpu_en never stays high for two consecutive cycles.
  - Exception: RUN with divider=1 strobes every cycle.
- instr_count:
  - Increments in every cycle cpu_en=1.
  - Wraps 16'hFFFF -> 16'h0000.
- Mid-operation reset returns everything to reset values immediately; a strobe in flight is cancelled.
- A div_load during RUN restarts the tick period from 0. It has no effect on state.

Test Plan (bench overrides DEBOUNCE_CYCLES=4; reset released at t=100ns):
- Free-run: div_load with div_value=4, run_sw=1 -> state=01; cpu_en pulses one cycle every 4 clk50 cycles; instr_count=5 after 20 cycles in RUN; run_sw=0 -> state=00 next cycle, pulses stop.
- Debounce/step: in IDLE, step_btn toggles 1,0,1 at 1-cycle spacing, then held 1 -> exactly one cpu_en pulse, asserted 2 (sync) + 4 (debounce) + 2 cycles after the final rise; instr_count +1.
- Breakpoint: bp_en=1, bp_addr=8'h03, run with div=1, ReadAddress driven 0,1,2,3 -> three strobes, then state=11 and cpu_halted=1 with ReadAddress=3 held; a step press gives one strobe, state 10->00.
- Simultaneous events: in IDLE, run_sw rises in the same cycle as step_pulse -> state=01, no STEP cycle; in RUN, a step press produces no extra strobe.
- div_value=0 loaded in RUN -> cpu_en high every cycle; instr_count preset near wrap by running 65536 strobes -> rolls to 0.
- Reset mid-run: reset=0 asserted asynchronously between clock edges with cpu_en=1 -> cpu_en, state, instr_count go 0 before the next edge; after release, the divider register equals DIV_DEFAULT.
